// File: rtl/ball_serve_gen_pkg.sv
// Shared pingpong definitions for the serve generator: state encodings, screen constants,
// default playfield limits and the descriptor decode.
package ball_serve_gen_pkg;

  localparam int unsigned RandW        = 10;
  localparam int unsigned ScreenH      = 480;
  localparam int unsigned PaddleH      = 48;
  localparam int unsigned DefYMin      = 16;
  localparam int unsigned DefYMax      = 463;
  localparam int unsigned DefFallbackY = 240;
  localparam int unsigned DefMaxTries  = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSample = 2'd1,
    StHold   = 2'd2
  } serve_state_e;

  typedef struct packed {
    logic [RandW-1:0] y;
    logic             dir_y;
    logic [1:0]       speed;
  } serve_desc_t;

  // Forcing bit 0 of the speed restricts the code to the legal values 1 and 3.
  function automatic serve_desc_t decode_sample(logic [RandW-1:0] word);
    serve_desc_t d;
    d.y     = word;
    d.dir_y = word[0];
    d.speed = word[1:0] | 2'b01;
    return d;
  endfunction

endpackage

// File: rtl/ball_serve_gen_if.sv
// Serve request / descriptor bundle between LFSR + game control and the ball-motion block.
// Optional statistics signals exist only when SERVE_STATS_EN is defined.
interface ball_serve_gen_if;
  logic [9:0] rand_word;
  logic       serve_req;
  logic       side;
  logic       ready;
  logic       valid;
  logic [9:0] y;
  logic       dir_x;
  logic       dir_y;
  logic [1:0] speed;
  logic       busy;
`ifdef SERVE_STATS_EN
  logic [7:0] fallback_cnt;
  logic [3:0] last_tries;
`endif

  modport master (
    input  rand_word, serve_req, side, ready,
    output valid, y, dir_x, dir_y, speed, busy
`ifdef SERVE_STATS_EN
    , output fallback_cnt, last_tries
`endif
  );

  modport slave (
    output rand_word, serve_req, side, ready,
    input  valid, y, dir_x, dir_y, speed, busy
`ifdef SERVE_STATS_EN
    , input fallback_cnt, last_tries
`endif
  );
endinterface

// File: rtl/ball_serve_gen.sv
// Ball-serve descriptor generator: rejection-samples the LFSR word into the playfield with a
// fixed fallback row. Define SERVE_STATS_EN to add fallback count and last-tries outputs.
module ball_serve_gen
  import ball_serve_gen_pkg::*;
#(
  parameter int unsigned YMin      = DefYMin,
  parameter int unsigned YMax      = DefYMax,
  parameter int unsigned MaxTries  = DefMaxTries,
  parameter int unsigned FallbackY = DefFallbackY
) (
  input  logic             clk,
  input  logic             rst,
  ball_serve_gen_if.master bus
);

  localparam logic [RandW-1:0] YMinW      = RandW'(YMin);
  localparam logic [RandW-1:0] YMaxW      = RandW'(YMax);
  localparam logic [RandW-1:0] FallbackYW = RandW'(FallbackY);
  localparam logic [3:0]       LastTry    = 4'(MaxTries - 1);

  serve_state_e state_q, state_d;
  serve_desc_t  desc_q, desc_d;
  logic [3:0]   tries_q, tries_d;
  logic         dir_x_q, dir_x_d;
  logic         valid_q, valid_d;
  logic         busy_q;
  logic         in_range;
  logic         accept_hit, fallback_hit;

  assign in_range = (bus.rand_word >= YMinW) && (bus.rand_word <= YMaxW);

  always_comb begin
    state_d      = state_q;
    desc_d       = desc_q;
    tries_d      = tries_q;
    dir_x_d      = dir_x_q;
    valid_d      = valid_q;
    accept_hit   = 1'b0;
    fallback_hit = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.serve_req) begin
          state_d = StSample;
          dir_x_d = ~bus.side;
          tries_d = '0;
        end
      end
      StSample: begin
        if (in_range) begin
          accept_hit = 1'b1;
          desc_d     = decode_sample(bus.rand_word);
          state_d    = StHold;
          valid_d    = 1'b1;
        end else begin
          tries_d = tries_q + 4'd1;
          if (tries_q == LastTry) begin
            fallback_hit = 1'b1;
            desc_d       = '{y: FallbackYW, dir_y: 1'b0, speed: 2'd1};
            state_d      = StHold;
            valid_d      = 1'b1;
          end
        end
      end
      StHold: begin
        if (bus.ready) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      desc_q  <= '0;
      tries_q <= '0;
      dir_x_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
      tries_q <= tries_d;
      dir_x_q <= dir_x_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign bus.valid = valid_q;
  assign bus.y     = desc_q.y;
  assign bus.dir_x = dir_x_q;
  assign bus.dir_y = desc_q.dir_y;
  assign bus.speed = desc_q.speed;
  assign bus.busy  = busy_q;

`ifdef SERVE_STATS_EN
  logic [7:0] fallback_cnt_q;
  logic [3:0] last_tries_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fallback_cnt_q <= '0;
      last_tries_q   <= '0;
    end else begin
      if (fallback_hit && (fallback_cnt_q != 8'hFF)) begin
        fallback_cnt_q <= fallback_cnt_q + 8'd1;
      end
      if (accept_hit || fallback_hit) begin
        last_tries_q <= tries_d;
      end
    end
  end

  assign bus.fallback_cnt = fallback_cnt_q;
  assign bus.last_tries   = last_tries_q;
`else
  // Kept so both hold-entry strobes stay referenced in the default build.
  logic unused_hits;
  assign unused_hits = accept_hit ^ fallback_hit;
`endif

endmodule
